// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_8
// Brief    : 8-way round-robin arbiter with registered one-hot and encoded
//            grant. Define ARB_TIMEOUT_EN to enable the per-owner hold limit.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_8 #(
    parameter int NREQ     = 8,
    parameter int IDX_W    = 3,
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    if (NREQ != 8 || IDX_W != 3 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_param_check
        $error("rr_arbiter_8: illegal parameter set");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  w_gnt_nxt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_gnt_idx_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_ptr_nxt;

    logic [NREQ-1:0]  w_cand;
    logic [NREQ-1:0]  w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W-1:0] w_win;
    logic             w_any;
    logic             w_owner_req;
    logic             w_expire;
    logic             w_take;

    // The owner is masked out of the search; when it has dropped its request
    // this changes nothing, and on a forced rotation it keeps the owner from
    // winning again. rr_ptr always equals owner+1, so it is the search start.
    assign w_cand      = req & ~r_gnt;
    assign w_any       = |w_cand;
    assign w_owner_req = |(req & r_gnt);

    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = w_cand[r_rr_ptr + IDX_W'(i)];
        end
    end

    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    assign w_win = r_rr_ptr + w_off;

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_idx_nxt = r_gnt_idx;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_take        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_take = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req) begin
                    if (w_any) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (w_expire && w_any) begin
                    w_take = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
        if (w_take) begin
            w_state_nxt   = ST_GRANT;
            w_gnt_nxt     = NREQ'(1) << w_win;
            w_gnt_idx_nxt = w_win;
            w_rr_ptr_nxt  = w_win + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_hold_max = 8'(HOLD_MAX);

    logic [7:0] r_hold_cnt;
    logic       r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            // A take while the owner still requests can only be a forced rotation.
            r_timeout <= w_take && w_owner_req;
            if (w_take) begin
                r_hold_cnt <= '0;
            end else if (r_state == ST_GRANT && r_hold_cnt != c_hold_max) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    // >= so a waiter arriving after saturation still gets its turn.
    assign w_expire = (r_hold_cnt >= c_hold_max - 8'd1);
    assign timeout  = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = (r_state == ST_GRANT);

endmodule
`default_nettype wire

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- 8-requester round-robin arbiter that owns a shared resource selected through the team's 3-to-8 decoder.
- Produces the encoded owner index that feeds the decoder select input.
- Also produces a registered one-hot grant for requesters that need it directly.
- Grants are held while the owner keeps requesting; ownership then rotates fairly.

Parameters:
- NREQ, 8, number of requesters; fixed at 8 to match the 3-bit decoder select.
- IDX_W, 3, width of the encoded grant index; log2(NREQ).
- HOLD_MAX, 16, maximum consecutive grant cycles per owner; used only with ARB_TIMEOUT_EN; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- req  input  8  request vector; bit i = requester i; level-sensitive.
- gnt  output  8  registered one-hot grant; all-zero when idle.
- gnt_idx  output  3  encoded owner index; drives the decoder select; valid only while gnt_valid=1.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on a forced rotation; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst_n=0, asynchronous): gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, state=IDLE, rr_ptr=3'd0, hold_cnt=0.
- Release of reset is synchronous to clk.
- All outputs are registered. Latency from req to gnt is 1 cycle.
- rr_ptr is the search start: requester i is checked in order rr_ptr, rr_ptr+1, ... modulo 8, and the first asserted req wins.
- State IDLE:
  - req==0: stay in IDLE.
  - req!=0: at the next edge, set gnt=onehot(w), gnt_idx=w, gnt_valid=1, and go to GRANT, where w is the winner.
- State GRANT (owner o):
  - req[o]==1: hold the grant unchanged.
  - req[o]==0, other requests present: switch at the next edge directly to the new winner, searching from o+1 (mod 8). There is no idle gap; gnt changes from one one-hot value to another within a single cycle.
  - req[o]==0, no other requests: next edge gnt=0, gnt_valid=0, go to IDLE.
  - On every grant change, rr_ptr <= owner+1 mod 8. Wrap-around: owner 7 -> rr_ptr=0.
- Request behaviour:
  - A requester that is not granted may drop req at any time with no effect.
  - A newly arriving req never preempts the current owner.
  - A requester whose req drops in the same cycle that it wins is still granted for one cycle, then released by the normal drop rule.
- Invariants:
  - gnt is always all-zero or exactly one-hot.
  - gnt_idx equals the encoded gnt whenever gnt_valid=1; gnt_idx holds its last value in IDLE.
- Reset asserted mid-grant: outputs clear immediately, without waiting for clk; the ownership history is lost and rr_ptr returns to 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt counts consecutive GRANT cycles of the current owner, saturating at HOLD_MAX, and resets to 0 on every grant change.
  - If hold_cnt==HOLD_MAX-1, req[o]==1, and another req is asserted, the next edge forces rotation to the next winner (search from o+1), and timeout pulses high for that one cycle.
  - If no other requester is waiting, the owner keeps the grant and hold_cnt stays saturated.
- Not defined: no hold_cnt register, the owner holds indefinitely, and timeout is constant 0.

Test Plan:
- Reset and idle: rst_n=0, then req=8'h00 for 5 cycles -> gnt=8'h00, gnt_valid=0, gnt_idx=0 throughout.
- Single request: req=8'h10 asserted at cycle 0 -> gnt=8'h10, gnt_idx=4 at cycle 1, held while req stays high. Drop req -> gnt=0 one cycle later.
- Rotation with wrap: req=8'h81 held, each owner drops its req for one cycle after 3 cycles of grant, then re-requests -> grants alternate 8'h01, 8'h80, 8'h01, with rr_ptr wrapping 7->0. No back-to-back grant to the same requester while the other is waiting.
- Back-to-back switch: owner 2 with req=8'h24, then req[2] drops -> the next cycle shows gnt=8'h20 directly, with gnt_valid never deasserted.
- Async reset mid-grant: gnt=8'h08, rst_n pulled low between edges -> gnt=0 and gnt_valid=0 before the next clk edge. After release with req=8'h0C -> gnt=8'h04 (rr_ptr=0).
- ARB_TIMEOUT_EN, HOLD_MAX=4: req=8'h03 held constantly -> gnt=8'h01 for 4 cycles, timeout pulse, gnt=8'h02 for 4 cycles, timeout pulse, then repeats. With req=8'h01 only -> the grant is held indefinitely and timeout stays 0.
